// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and default frame-check parameters.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_NUM_STOP   = 1;
  localparam int DEF_DATA_W     = 8;

endpackage

// File: rtl/rx_majority3.sv
// rx_majority3: 2-of-3 vote plus a flag when the three samples are not unanimous.
module rx_majority3 (
  input  logic s0,
  input  logic s1,
  input  logic s2,
  output logic maj,
  output logic disagree
);

  assign maj      = (s0 & s1) | (s0 & s2) | (s1 & s2);
  assign disagree = (s0 ^ s1) | (s1 ^ s2);

endmodule

// File: rtl/rx_frame_check.sv
// rx_frame_check: stop-bit checker for a UART receiver.
// Started by chk_stop, it samples each stop bit mid-bit, reports framing
// error / break / noise, and keeps a saturating count of bad frames.
// Build option RX_STOP_NOISE_EN: three-sample majority vote and noise_error;
// without it a single centre sample decides and noise_error is 0.
module rx_frame_check
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int NUM_STOP   = DEF_NUM_STOP,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic              chk_stop,
  input  logic              rx_data_in,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              err_clr,
  output logic              busy,
  output logic              frame_done,
  output logic              stop_bit_error,
  output logic              break_det,
  output logic              noise_error,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0]    T_S0    = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0]    T_S1    = TW'(OVERSAMPLE/2);
  localparam logic [TW-1:0]    T_S2    = TW'(OVERSAMPLE/2 + 1);
  localparam logic [TW-1:0]    T_MAX   = TW'(OVERSAMPLE - 1);
  localparam logic             B_LAST  = 1'(NUM_STOP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state, w_next;
  logic [TW-1:0]    r_tick;
  logic             r_bit;
  logic             r_s1;
  logic             r_acc_err;
  logic             r_stop_err, r_brk;
  logic [CNT_W-1:0] r_cnt;
  logic             w_tick, w_vote_pt, w_last, w_vote;

  assign w_tick    = (r_state == CHECK) && sample_tick;
  // The last sample position of each bit is where that bit's vote resolves.
  assign w_vote_pt = w_tick && (r_tick == T_S2);
  assign w_last    = w_vote_pt && (r_bit == B_LAST);

`ifdef RX_STOP_NOISE_EN
  logic r_s0;
  logic r_acc_noise, r_noise;
  logic w_dis;

  // Third sample is taken live from the line on the resolving tick.
  rx_majority3 u_maj (
    .s0       (r_s0),
    .s1       (r_s1),
    .s2       (rx_data_in),
    .maj      (w_vote),
    .disagree (w_dis)
  );

  // First sample of the vote window
  always_ff @(posedge clk) begin
    if (reset)                          r_s0 <= 1'b0;
    else if (w_tick && r_tick == T_S0)  r_s0 <= rx_data_in;
  end

  // Any non-unanimous stop bit in the current frame marks it noisy
  always_ff @(posedge clk) begin
    if (reset)                                r_acc_noise <= 1'b0;
    else if (r_state == IDLE && chk_stop)     r_acc_noise <= 1'b0;
    else if (w_vote_pt)                       r_acc_noise <= r_acc_noise | w_dis;
  end

  // Noise result published with the other flags
  always_ff @(posedge clk) begin
    if (reset)                 r_noise <= 1'b0;
    else if (r_state == DONE)  r_noise <= r_acc_noise;
  end

  assign noise_error = r_noise;
`else
  // Centre sample alone decides the bit.
  assign w_vote      = r_s1;
  assign noise_error = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state and status strobes; chk_stop outside IDLE is ignored
  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (r_state)
      IDLE:    if (chk_stop) w_next = CHECK;
      CHECK: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Oversample position within the stop window; only real ticks advance it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick <= '0;
      r_bit  <= 1'b0;
    end else if (r_state == IDLE && chk_stop) begin
      r_tick <= '0;
      r_bit  <= 1'b0;
    end else if (w_tick) begin
      if (r_tick == T_MAX) begin
        r_tick <= '0;
        r_bit  <= r_bit + 1'b1;
      end else begin
        r_tick <= r_tick + 1'b1;
      end
    end
  end

  // Centre sample of the current bit
  always_ff @(posedge clk) begin
    if (reset)                          r_s1 <= 1'b0;
    else if (w_tick && r_tick == T_S1)  r_s1 <= rx_data_in;
  end

  // Any stop bit voted 0 marks the frame bad
  always_ff @(posedge clk) begin
    if (reset)                             r_acc_err <= 1'b0;
    else if (r_state == IDLE && chk_stop)  r_acc_err <= 1'b0;
    else if (w_vote_pt)                    r_acc_err <= r_acc_err | ~w_vote;
  end

  // Publish frame result in DONE; held until the next frame completes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stop_err <= 1'b0;
      r_brk      <= 1'b0;
    end else if (r_state == DONE) begin
      r_stop_err <= r_acc_err;
      r_brk      <= r_acc_err && (rx_data == '0);
    end
  end

  // Saturating bad-frame counter; a clear coinciding with a bad frame leaves 1
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == DONE && r_acc_err) begin
      if (err_clr)               r_cnt <= CNT_W'(1);
      else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
    end else if (err_clr) begin
      r_cnt <= '0;
    end
  end

  assign stop_bit_error = r_stop_err;
  assign break_det      = r_brk;
  assign err_cnt        = r_cnt;

endmodule

// File: tb/tb_rx_frame_check.sv
// tb_rx_frame_check: directed + randomized checks of rx_frame_check.
// Two instances: A (1 stop bit, 8-bit counter) and B (2 stop bits, 2-bit
// counter). Expected results come from a per-frame model built from the
// sampling rules (sample positions, vote, saturating count).
module tb_rx_frame_check;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       reset, sample_tick, rx_data_in;
  logic [7:0] rx_data;
  logic [1:0] chk, clr;

  logic       busy_a, done_a, serr_a, brk_a, nerr_a;
  logic [7:0] cnt_a;
  logic       busy_b, done_b, serr_b, brk_b, nerr_b;
  logic [1:0] cnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic ln [64];
  int   exp_serr [2];
  int   exp_brk  [2];
  int   exp_nerr [2];
  int   exp_cnt  [2];

  always #5 clk = ~clk;

  rx_frame_check #(.OVERSAMPLE(OS), .NUM_STOP(1), .DATA_W(8), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .chk_stop(chk[0]),
    .rx_data_in(rx_data_in), .rx_data(rx_data), .err_clr(clr[0]),
    .busy(busy_a), .frame_done(done_a), .stop_bit_error(serr_a),
    .break_det(brk_a), .noise_error(nerr_a), .err_cnt(cnt_a)
  );

  rx_frame_check #(.OVERSAMPLE(OS), .NUM_STOP(2), .DATA_W(8), .CNT_W(2)) u_b (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .chk_stop(chk[1]),
    .rx_data_in(rx_data_in), .rx_data(rx_data), .err_clr(clr[1]),
    .busy(busy_b), .frame_done(done_b), .stop_bit_error(serr_b),
    .break_det(brk_b), .noise_error(nerr_b), .err_cnt(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input int w, input string tag, input bit busy_e, input bit done_e);
    if (w == 0) begin
      check({tag, ".A.busy"}, 32'(busy_a), 32'(busy_e));
      check({tag, ".A.done"}, 32'(done_a), 32'(done_e));
      check({tag, ".A.serr"}, 32'(serr_a), exp_serr[0]);
      check({tag, ".A.brk"},  32'(brk_a),  exp_brk[0]);
      check({tag, ".A.nerr"}, 32'(nerr_a), exp_nerr[0]);
      check({tag, ".A.cnt"},  32'(cnt_a),  exp_cnt[0]);
    end else begin
      check({tag, ".B.busy"}, 32'(busy_b), 32'(busy_e));
      check({tag, ".B.done"}, 32'(done_b), 32'(done_e));
      check({tag, ".B.serr"}, 32'(serr_b), exp_serr[1]);
      check({tag, ".B.brk"},  32'(brk_b),  exp_brk[1]);
      check({tag, ".B.nerr"}, 32'(nerr_b), exp_nerr[1]);
      check({tag, ".B.cnt"},  32'(cnt_b),  exp_cnt[1]);
    end
  endtask

  task automatic zero_model();
    for (int i = 0; i < 2; i++) begin
      exp_serr[i] = 0; exp_brk[i] = 0; exp_nerr[i] = 0; exp_cnt[i] = 0;
    end
  endtask

  // One stop-bit check on instance w using line pattern ln[] (index = tick
  // number after chk_stop). abort_at >= 0 asserts reset on that tick.
  task automatic run_frame(input int w, input string tag, input logic [7:0] data,
                           input bit clr_done, input int abort_at);
    int  ns, last, maxc, e_err, e_nrs, gap;
    logic s0, s1, s2, v;
    ns    = (w == 1) ? 2 : 1;
    maxc  = (w == 1) ? 3 : 255;
    last  = (ns - 1) * OS + OS/2 + 1;
    e_err = 0;
    e_nrs = 0;
    for (int b = 0; b < ns; b++) begin
      s0 = ln[b*OS + OS/2 - 1];
      s1 = ln[b*OS + OS/2];
      s2 = ln[b*OS + OS/2 + 1];
`ifdef RX_STOP_NOISE_EN
      v = (int'(s0) + int'(s1) + int'(s2)) >= 2;
      if (!(s0 == s1 && s1 == s2)) e_nrs = 1;
`else
      v = s1;
`endif
      if (!v) e_err = 1;
    end

    rx_data     = data;
    chk[w]      = 1'b1;
    sample_tick = 1'b1;
    rx_data_in  = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk = 2'b00; sample_tick = 1'b0;
    check_state(w, {tag, ".start"}, 1'b1, 1'b0);

    for (int k = 0; k <= last; k++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        sample_tick = 1'b0;
        rx_data_in  = 1'($urandom_range(0, 1));
        chk[w]      = ($urandom_range(0, 5) == 0);
        @(negedge clk);
        chk = 2'b00;
        check_state(w, {tag, ".gap"}, 1'b1, 1'b0);
      end
      sample_tick = 1'b1;
      rx_data_in  = ln[k];
      chk[w]      = ($urandom_range(0, 5) == 0);
      if (k == abort_at) reset = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0; chk = 2'b00;
      if (k == abort_at) begin
        reset = 1'b0;
        zero_model();
        check_state(0, {tag, ".abort"}, 1'b0, 1'b0);
        check_state(1, {tag, ".abort"}, 1'b0, 1'b0);
        for (int j = 0; j < 2*OS; j++) begin
          sample_tick = 1'($urandom_range(0, 1));
          rx_data_in  = 1'($urandom_range(0, 1));
          @(negedge clk);
          check({tag, ".abort.nodone"}, 32'(w ? done_b : done_a), 32'd0);
        end
        sample_tick = 1'b0;
        return;
      end
      if (k < last) check_state(w, {tag, ".tick"}, 1'b1, 1'b0);
      else          check_state(w, {tag, ".done"}, 1'b0, 1'b1);
    end

    // DONE cycle: optional clear, stray chk_stop must not restart
    clr[w]      = clr_done;
    chk[w]      = 1'($urandom_range(0, 1));
    sample_tick = 1'($urandom_range(0, 1));
    @(negedge clk);
    clr = 2'b00; chk = 2'b00; sample_tick = 1'b0;
    exp_serr[w] = e_err;
    exp_brk[w]  = (e_err != 0 && data == 8'h00) ? 1 : 0;
    exp_nerr[w] = e_nrs;
    if (e_err != 0) exp_cnt[w] = clr_done ? 1 : ((exp_cnt[w] < maxc) ? exp_cnt[w] + 1 : maxc);
    else if (clr_done) exp_cnt[w] = 0;
    check_state(w, {tag, ".post"}, 1'b0, 1'b0);
  endtask

  task automatic fill(input logic val);
    for (int k = 0; k < 64; k++) ln[k] = val;
  endtask

  task automatic pulse_clr(input int w);
    clr[w] = 1'b1;
    @(negedge clk);
    clr = 2'b00;
    exp_cnt[w] = 0;
    check_state(w, "clr", 1'b0, 1'b0);
  endtask

  initial begin
    // Reset wins over chk_stop and err_clr asserted alongside it
    reset = 1'b1; sample_tick = 1'b1; rx_data_in = 1'b1; rx_data = 8'h00;
    chk = 2'b11; clr = 2'b11;
    zero_model();
    repeat (3) @(negedge clk);
    check_state(0, "reset", 1'b0, 1'b0);
    check_state(1, "reset", 1'b0, 1'b0);
    reset = 1'b0; chk = 2'b00; clr = 2'b00; sample_tick = 1'b0;
    @(negedge clk);
    check_state(0, "idle", 1'b0, 1'b0);

    // Clean line
    fill(1'b1);
    run_frame(0, "clean", 8'h3C, 1'b0, -1);
    check("clean.cnt", 32'(cnt_a), 32'd0);

    // Line held low with zero data: framing error and break
    fill(1'b0);
    run_frame(0, "break", 8'h00, 1'b0, -1);
    check("break.flag", 32'(brk_a), 32'd1);
    check("break.cnt", 32'(cnt_a), 32'd1);

    // Single glitch on the centre sample
    fill(1'b1); ln[8] = 1'b0;
    run_frame(0, "glitch", 8'h11, 1'b0, -1);

    // Second stop bit bad, data non-zero: error without break
    fill(1'b1); ln[23] = 1'b0; ln[24] = 1'b0; ln[25] = 1'b0;
    run_frame(1, "stop2", 8'hA5, 1'b0, -1);
    check("stop2.serr", 32'(serr_b), 32'd1);
    check("stop2.brk", 32'(brk_b), 32'd0);

    // err_clr alone
    pulse_clr(0);
    pulse_clr(1);

    // Randomized frames on both instances
    for (int f = 0; f < 24; f++) begin
      int w;
      logic [7:0] d;
      w = $urandom_range(0, 1);
      for (int k = 0; k < 64; k++) ln[k] = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 4) == 0) fill(1'b0);
      d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      run_frame(w, "rand", d, ($urandom_range(0, 4) == 0), -1);
    end

    // Counter saturation on the 2-bit counter, then clear with a bad frame
    pulse_clr(1);
    fill(1'b0);
    for (int f = 0; f < 4; f++) run_frame(1, "sat", 8'hA5, 1'b0, -1);
    check("sat.cnt", 32'(cnt_b), 32'd3);
    run_frame(1, "satclr", 8'hA5, 1'b1, -1);
    check("satclr.cnt", 32'(cnt_b), 32'd1);

    // Reset mid-check aborts the frame; a fresh check then behaves normally
    fill(1'b0);
    run_frame(0, "abort", 8'h00, 1'b0, 5);
    fill(1'b1);
    run_frame(0, "after", 8'h5A, 1'b0, -1);
    check("after.serr", 32'(serr_a), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
